// File: rtl/renderizador_texto_if.sv
// Pixel-path bundle for the text overlay renderer: beam counters, frame
// strobe, string-buffer write port, font ROM port and the rendered pixel.
interface renderizador_texto_if #(
    parameter int N_CAR  = 8,
    parameter int CODE_W = 6
);
    localparam int IDX_W = (N_CAR > 1) ? $clog2(N_CAR) : 1;

    logic [9:0]        Qh;
    logic [9:0]        Qv;
    logic              fin_cuadro;
    logic              we;
    logic [IDX_W-1:0]  wr_idx;
    logic [CODE_W-1:0] wr_car;
    logic              wr_parp;
    logic [CODE_W+3:0] rom_dir;
    logic [7:0]        rom_dato;
    logic              bit_fuente;
    logic              en_texto;

    // Renderer side.
    modport slave (
        input  Qh, Qv, fin_cuadro, we, wr_idx, wr_car, wr_parp, rom_dato,
        output rom_dir, bit_fuente, en_texto
    );

    // Video timing / CPU / ROM side.
    modport master (
        output Qh, Qv, fin_cuadro, we, wr_idx, wr_car, wr_parp, rom_dato,
        input  rom_dir, bit_fuente, en_texto
    );
endinterface

// File: rtl/renderizador_texto.sv
// Text overlay renderer: a writable string of glyph codes drawn at a tile
// origin, optional 2x scaling and per-character blink. Three-stage pipeline
// from the beam counters to the font pixel, using an external synchronous
// font ROM between stage 1 and stage 2.
module renderizador_texto #(
    parameter int N_CAR        = 8,
    parameter int CODE_W       = 6,
    parameter int COL0         = 43,
    parameter int FILA0        = 16,
    parameter int ESCALA       = 1,
    parameter int PERIODO_PARP = 30
) (
    input logic                 reloj,
    input logic                 resetM,
    renderizador_texto_if.slave bus
);
    localparam int IDX_W  = (N_CAR > 1) ? $clog2(N_CAR) : 1;
    localparam int N_SLOT = 1 << IDX_W;
    localparam int X0     = COL0 * 8;
    localparam int Y0     = FILA0 * 16;
    localparam int ANCHO  = N_CAR * 8 * ESCALA;
    localparam int ALTO   = 16 * ESCALA;
    localparam int S      = ESCALA - 1;
    localparam int CNT_W  = (PERIODO_PARP > 1) ? $clog2(PERIODO_PARP) : 1;

    localparam logic [10:0]      X0_V     = 11'(X0);
    localparam logic [10:0]      Y0_V     = 11'(Y0);
    localparam logic [10:0]      ANCHO_V  = 11'(ANCHO);
    localparam logic [10:0]      ALTO_V   = 11'(ALTO);
    localparam logic [IDX_W:0]   N_CAR_V  = (IDX_W + 1)'(N_CAR);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PERIODO_PARP - 1);

    // Parameter sanity: a box that does not fit the 1024x1024 counter space
    // or an unsupported scale must not build.
    if (N_CAR < 1 || N_CAR > 16) begin : g_err_ncar
        $error("renderizador_texto: N_CAR must be 1..16");
    end
    if (ESCALA != 1 && ESCALA != 2) begin : g_err_escala
        $error("renderizador_texto: ESCALA must be 1 or 2");
    end
    if (PERIODO_PARP < 1) begin : g_err_periodo
        $error("renderizador_texto: PERIODO_PARP must be >= 1");
    end
    if (X0 + ANCHO > 1024) begin : g_err_ancho
        $error("renderizador_texto: text box exceeds horizontal range");
    end
    if (Y0 + ALTO > 1024) begin : g_err_alto
        $error("renderizador_texto: text box exceeds vertical range");
    end

    // String buffer. Sized to a power of two so any idx is a legal index;
    // slots at or above N_CAR are never written and stay blank.
    logic [CODE_W-1:0] buf_code [N_SLOT];
    logic [N_SLOT-1:0] buf_parp;

    // Blink state.
    logic [CNT_W-1:0] cnt_q;
    logic             fase_q;

    // Stage 0 combinational box test and coordinate split.
    logic [10:0] dx;
    logic [10:0] dy;
    logic        dentro_c;

    // Pipeline registers.
    logic [IDX_W-1:0]  idx_s0;
    logic [2:0]        px_s0;
    logic [3:0]        fila_s0;
    logic              dentro_s0;
    logic [CODE_W-1:0] code_rd;
    logic              parp_rd;
    logic [CODE_W+3:0] rom_dir_q;
    logic [2:0]        px_s1;
    logic              dentro_s1;
    logic              parp_s1;
    logic [2:0]        px_s2;
    logic              dentro_s2;
    logic              parp_s2;
    logic              rom_bit;
    logic              bit_q;
    logic              en_q;

    // Slot write; out-of-range indices are dropped, and a same-cycle stage-1
    // read naturally sees the old contents since both happen on the edge.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            for (int i = 0; i < N_SLOT; i++) begin
                buf_code[i] <= '0;
            end
            buf_parp <= '0;
        end else if (bus.we && ({1'b0, bus.wr_idx} < N_CAR_V)) begin
            buf_code[bus.wr_idx] <= bus.wr_car;
            buf_parp[bus.wr_idx] <= bus.wr_parp;
        end
    end

    // Frame counter: fase flips every PERIODO_PARP frames.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            cnt_q  <= '0;
            fase_q <= 1'b0;
        end else if (bus.fin_cuadro) begin
            if (cnt_q == CNT_MAX) begin
                cnt_q  <= '0;
                fase_q <= ~fase_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Offset from the box origin; an 11-bit borrow lands above 1023 and so
    // fails the size compare, which also covers counter wrap-around.
    always_comb begin
        dx       = {1'b0, bus.Qh} - X0_V;
        dy       = {1'b0, bus.Qv} - Y0_V;
        dentro_c = ~dx[10] & ~dy[10] & (dx < ANCHO_V) & (dy < ALTO_V);
    end

    // Stage 0: register slot index, pixel column, glyph row and box flag.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            idx_s0    <= '0;
            px_s0     <= '0;
            fila_s0   <= '0;
            dentro_s0 <= 1'b0;
        end else begin
            idx_s0    <= dx[S+3 +: IDX_W];
            px_s0     <= dx[S +: 3];
            fila_s0   <= dy[S +: 4];
            dentro_s0 <= dentro_c;
        end
    end

    // Buffer lookup; outside the box the blank glyph is addressed.
    always_comb begin
        code_rd = '0;
        parp_rd = 1'b0;
        if (dentro_s0) begin
            code_rd = buf_code[idx_s0];
            parp_rd = buf_parp[idx_s0];
        end
    end

    // Stage 1: issue the ROM address and carry the pixel context along.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            rom_dir_q <= '0;
            px_s1     <= '0;
            dentro_s1 <= 1'b0;
            parp_s1   <= 1'b0;
        end else begin
            rom_dir_q <= {code_rd, fila_s0};
            px_s1     <= px_s0;
            dentro_s1 <= dentro_s0;
            parp_s1   <= parp_rd;
        end
    end

    // Stage 2: wait out the ROM read cycle.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            px_s2     <= '0;
            dentro_s2 <= 1'b0;
            parp_s2   <= 1'b0;
        end else begin
            px_s2     <= px_s1;
            dentro_s2 <= dentro_s1;
            parp_s2   <= parp_s1;
        end
    end

    // Pick the pixel out of the ROM row, MSB leftmost.
    always_comb begin
        rom_bit = bus.rom_dato[3'd7 - px_s2];
    end

    // Output stage: gate by the box and by the blink phase.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            bit_q <= 1'b0;
            en_q  <= 1'b0;
        end else begin
            bit_q <= dentro_s2 & ~(parp_s2 & fase_q) & rom_bit;
            en_q  <= dentro_s2;
        end
    end

    assign bus.rom_dir    = rom_dir_q;
    assign bus.bit_fuente = bit_q;
    assign bus.en_texto   = en_q;

endmodule
